alu_arbiter: RTL and testbench

- Shares the single combinational 64-bit ALU between two requesters (e.g. execute stage and address-generation path).
- Each requester has a valid/ready request channel and a valid/ready response channel.
- The block arbitrates round-robin, holds operands stable on the ALU inputs, captures the result and flags, and returns them to the requester that owns the operation.
- Exactly one operation is in flight at a time.

---
 rtl/alu_arbiter.sv | 138 +++++++++++++
 tb/tb_alu_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Round-robin arbiter that time-shares one external combinational 64-bit ALU
// between two valid/ready requesters, one operation in flight at a time.
module alu_arbiter #(
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            req_valid,
  output logic [1:0]            req_ready,
  input  logic [1:0][63:0]      req_A,
  input  logic [1:0][63:0]      req_B,
  input  logic [1:0][2:0]       req_cntrl,
  output logic [1:0]            rsp_valid,
  input  logic [1:0]            rsp_ready,
  output logic [63:0]           rsp_result,
  output logic [3:0]            rsp_flags,
  output logic                  rsp_err,
  output logic [63:0]           alu_A,
  output logic [63:0]           alu_B,
  output logic [2:0]            alu_cntrl,
  input  logic [63:0]           alu_result,
  input  logic                  alu_negative,
  input  logic                  alu_zero,
  input  logic                  alu_overflow,
  input  logic                  alu_carry_out,
  output logic                  busy,
  output logic [CNT_W-1:0]      op_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state_q;
  logic              last_grant_q;
  logic              owner_q;
  logic [63:0]       op_a_q;
  logic [63:0]       op_b_q;
  logic [2:0]        op_cntrl_q;
  logic              op_illegal_q;
  logic [1:0]        rsp_valid_q;
  logic [63:0]       rsp_result_q;
  logic [3:0]        rsp_flags_q;
  logic              rsp_err_q;
  logic [CNT_W-1:0]  op_count_q;

  logic              any_req_d;
  logic              grant_d;
  logic [2:0]        grant_cntrl_d;
  logic              grant_illegal_d;
  logic              op_arith_d;
  logic              owner_rsp_ready_d;

  // On a tie the requester that was not served last wins; otherwise the sole requester.
  assign any_req_d       = |req_valid;
  assign grant_d         = (&req_valid) ? ~last_grant_q : req_valid[1];
  assign grant_cntrl_d   = req_cntrl[grant_d];
  assign grant_illegal_d = (grant_cntrl_d == 3'b001) || (grant_cntrl_d == 3'b111);
  assign op_arith_d      = (op_cntrl_q == 3'b010) || (op_cntrl_q == 3'b011);
  assign owner_rsp_ready_d = rsp_ready[owner_q];

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_ready
      if (gi == 0) begin : g_r0
        assign req_ready[gi] = (state_q == IDLE) && req_valid[gi] && !grant_d;
      end else begin : g_r1
        assign req_ready[gi] = (state_q == IDLE) && req_valid[gi] && grant_d;
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      op_a_q       <= '0;
      op_b_q       <= '0;
      op_cntrl_q   <= '0;
      op_illegal_q <= 1'b0;
      rsp_valid_q  <= '0;
      rsp_result_q <= '0;
      rsp_flags_q  <= '0;
      rsp_err_q    <= 1'b0;
      op_count_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (any_req_d) begin
            op_a_q       <= req_A[grant_d];
            op_b_q       <= req_B[grant_d];
            // Illegal codes are shown to the ALU as pass-B so its output stays well defined.
            op_cntrl_q   <= grant_illegal_d ? 3'b000 : grant_cntrl_d;
            op_illegal_q <= grant_illegal_d;
            owner_q      <= grant_d;
            state_q      <= EXEC;
          end
        end
        EXEC: begin
          if (op_illegal_q) begin
            rsp_result_q <= '0;
            rsp_flags_q  <= 4'b0100;
            rsp_err_q    <= 1'b1;
          end else begin
            rsp_result_q <= alu_result;
            rsp_flags_q  <= {alu_negative, alu_zero,
                             op_arith_d & alu_overflow, op_arith_d & alu_carry_out};
            rsp_err_q    <= 1'b0;
          end
          rsp_valid_q <= owner_q ? 2'b10 : 2'b01;
          state_q     <= RESP;
        end
        RESP: begin
          if (owner_rsp_ready_d) begin
            rsp_valid_q  <= '0;
            last_grant_q <= owner_q;
            op_count_q   <= op_count_q + CNT_W'(1);
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign alu_A      = op_a_q;
  assign alu_B      = op_b_q;
  assign alu_cntrl  = op_cntrl_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = rsp_result_q;
  assign rsp_flags  = rsp_flags_q;
  assign rsp_err    = rsp_err_q;
  assign busy       = (state_q != IDLE);
  assign op_count   = op_count_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed and randomized checks of alu_arbiter against an operation-level reference
// model; the bench also plays the role of the shared ALU.
module tb_alu_arbiter;

  localparam int CNT_W = 4;

  logic                 clk = 1'b0;
  logic                 reset = 1'b0;
  logic [1:0]           req_valid = '0;
  logic [1:0]           req_ready;
  logic [1:0][63:0]     req_A = '0;
  logic [1:0][63:0]     req_B = '0;
  logic [1:0][2:0]      req_cntrl = '0;
  logic [1:0]           rsp_valid;
  logic [1:0]           rsp_ready = '0;
  logic [63:0]          rsp_result;
  logic [3:0]           rsp_flags;
  logic                 rsp_err;
  logic [63:0]          alu_A;
  logic [63:0]          alu_B;
  logic [2:0]           alu_cntrl;
  logic [63:0]          alu_result;
  logic                 alu_negative;
  logic                 alu_zero;
  logic                 alu_overflow;
  logic                 alu_carry_out;
  logic                 busy;
  logic [CNT_W-1:0]     op_count;

  int          vectors = 0;
  int          miscompares = 0;
  int          m_cnt = 0;
  logic        m_last = 1'b1;
  logic        obs_w;
  logic [63:0] obs_res;
  logic [3:0]  obs_fl;
  logic        obs_err;
  logic [2:0]  obs_alu_c;

  alu_arbiter #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_A(req_A), .req_B(req_B), .req_cntrl(req_cntrl),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_flags(rsp_flags), .rsp_err(rsp_err),
    .alu_A(alu_A), .alu_B(alu_B), .alu_cntrl(alu_cntrl),
    .alu_result(alu_result), .alu_negative(alu_negative), .alu_zero(alu_zero),
    .alu_overflow(alu_overflow), .alu_carry_out(alu_carry_out),
    .busy(busy), .op_count(op_count)
  );

  always #5 clk = ~clk;

  // ALU returns {result, n, z, v, c}; logical ops report v=c=1 so the arbiter must mask them.
  function automatic logic [67:0] alu_ref(input logic [2:0] c, input logic [63:0] a, input logic [63:0] b);
    logic [64:0] s;
    logic [63:0] r;
    logic        v;
    logic        co;
    v = 1'b1;
    co = 1'b1;
    s = '0;
    case (c)
      3'b000: r = b;
      3'b010: begin
        s = {1'b0, a} + {1'b0, b};
        r = s[63:0];
        co = s[64];
        v = (a[63] == b[63]) && (r[63] != a[63]);
      end
      3'b011: begin
        s = {1'b0, a} + {1'b0, ~b} + 65'd1;
        r = s[63:0];
        co = s[64];
        v = (a[63] != b[63]) && (r[63] != a[63]);
      end
      3'b100: r = a & b;
      3'b101: r = a | b;
      3'b110: r = a ^ b;
      default: r = 64'hDEAD_BEEF_DEAD_BEEF;
    endcase
    return {r, r[63], (r == 64'd0), v, co};
  endfunction

  assign {alu_result, alu_negative, alu_zero, alu_overflow, alu_carry_out} = alu_ref(alu_cntrl, alu_A, alu_B);

  // Expected response {result, flags, err} for one operation.
  function automatic logic [68:0] model_rsp(input logic [2:0] c, input logic [63:0] a, input logic [63:0] b);
    logic [67:0] x;
    x = alu_ref(c, a, b);
    if (c == 3'b001 || c == 3'b111) return {64'd0, 4'b0100, 1'b1};
    if (c == 3'b010 || c == 3'b011) return {x, 1'b0};
    return {x[67:4], x[3], x[2], 2'b00, 1'b0};
  endfunction

  function automatic logic [63:0] rand64();
    case ($urandom_range(0, 4))
      0: return 64'h7FFF_FFFF_FFFF_FFFF;
      1: return 64'hFFFF_FFFF_FFFF_FFFF;
      2: return 64'd0;
      3: return 64'h8000_0000_0000_0000;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    req_valid = '0;
    rsp_ready = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
    m_cnt = 0;
    m_last = 1'b1;
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_op_count", 64'(op_count), 64'd0);
    chk("rst_rsp_result", rsp_result, 64'd0);
    chk("rst_rsp_flags_err", 64'({rsp_flags, rsp_err}), 64'd0);
    chk("rst_alu_ops", 64'(alu_A | alu_B | 64'(alu_cntrl)), 64'd0);
    $display("reset applied");
  endtask

  // Serves the request the model says wins next; requests must already be on the inputs.
  task automatic run_op(input int hold);
    logic        w;
    logic [2:0]  c;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] eres;
    logic [3:0]  efl;
    logic        eerr;
    logic [1:0]  rr;
    #1;
    w = (req_valid == 2'b11) ? ~m_last : req_valid[1];
    chk("grant_ready", 64'(req_ready), w ? 64'd2 : 64'd1);
    c = req_cntrl[w];
    a = req_A[w];
    b = req_B[w];
    {eres, efl, eerr} = model_rsp(c, a, b);
    @(posedge clk);
    #1;
    req_valid[w] = 1'b0;
    chk("exec_busy", 64'(busy), 64'd1);
    chk("exec_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("exec_req_ready", 64'(req_ready), 64'd0);
    chk("exec_alu_A", alu_A, a);
    chk("exec_alu_B", alu_B, b);
    chk("exec_alu_cntrl", 64'(alu_cntrl), eerr ? 64'd0 : 64'(c));
    obs_alu_c = alu_cntrl;
    @(posedge clk);
    #1;
    chk("resp_valid", 64'(rsp_valid), w ? 64'd2 : 64'd1);
    chk("resp_result", rsp_result, eres);
    chk("resp_flags", 64'(rsp_flags), 64'(efl));
    chk("resp_err", 64'(rsp_err), 64'(eerr));
    obs_w = w;
    obs_res = rsp_result;
    obs_fl = rsp_flags;
    obs_err = rsp_err;
    for (int i = 0; i < hold; i++) begin
      rr = 2'($urandom);
      rr[w] = 1'b0;
      rsp_ready = rr;
      @(posedge clk);
      #1;
      chk("hold_valid", 64'(rsp_valid), w ? 64'd2 : 64'd1);
      chk("hold_data", {rsp_result[59:0], rsp_flags}, {obs_res[59:0], obs_fl});
      chk("hold_req_ready", 64'(req_ready), 64'd0);
      chk("hold_busy", 64'(busy), 64'd1);
      chk("hold_alu_A", alu_A, a);
    end
    rr = 2'($urandom);
    rr[w] = 1'b1;
    rsp_ready = rr;
    @(posedge clk);
    #1;
    rsp_ready = '0;
    m_cnt++;
    m_last = w;
    chk("done_op_count", 64'(op_count), 64'(m_cnt % (1 << CNT_W)));
    chk("done_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("done_busy", 64'(busy), 64'd0);
    $display("op r%0d cntrl=%b A=%h B=%h -> result=%h flags=%b err=%b hold=%0d count=%0d",
             w, c, a, b, obs_res, obs_fl, obs_err, hold, op_count);
  endtask

  task automatic set_req(input int r, input logic [2:0] c, input logic [63:0] a, input logic [63:0] b);
    req_valid[r] = 1'b1;
    req_cntrl[r] = c;
    req_A[r] = a;
    req_B[r] = b;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    do_reset();

    // Single add from requester 0.
    set_req(0, 3'b010, 64'd1, 64'd1);
    run_op(0);
    chk("add_owner", 64'(obs_w), 64'd0);
    chk("add_result", obs_res, 64'd2);
    chk("add_flags", 64'(obs_fl), 64'b0000);
    chk("add_err", 64'(obs_err), 64'd0);
    chk("add_count", 64'(op_count), 64'd1);

    // Tie straight after reset: requester 0 first, then 1, then 0 again.
    do_reset();
    set_req(0, 3'b011, 64'd1, 64'd2);
    set_req(1, 3'b110, 64'h11, 64'h01);
    run_op(0);
    chk("tie_first_owner", 64'(obs_w), 64'd0);
    chk("sub_result", obs_res, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("sub_flags", 64'(obs_fl), 64'b1000);
    run_op(0);
    chk("tie_second_owner", 64'(obs_w), 64'd1);
    chk("xor_result", obs_res, 64'h10);
    chk("xor_flags", 64'(obs_fl), 64'b0000);
    set_req(0, 3'b101, rand64(), rand64());
    set_req(1, 3'b100, rand64(), rand64());
    run_op(1);
    chk("tie_again_owner", 64'(obs_w), 64'd0);
    run_op(0);

    // Signed overflow, then a repeat grant to the same lone requester.
    set_req(1, 3'b010, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1);
    run_op(0);
    chk("ovf_result", obs_res, 64'h8000_0000_0000_0000);
    chk("ovf_flags", 64'(obs_fl), 64'b1010);
    set_req(1, 3'b000, 64'd3, 64'd0);
    run_op(0);
    chk("repeat_owner", 64'(obs_w), 64'd1);
    chk("passb_zero_flags", 64'(obs_fl), 64'b0100);

    // Backpressure on requester 0 while requester 1 waits.
    set_req(0, 3'b010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
    set_req(1, 3'b011, 64'd5, 64'd7);
    run_op(5);
    chk("bp_owner", 64'(obs_w), 64'd0);
    chk("bp_carry_flags", 64'(obs_fl), 64'b0101);
    run_op(0);
    chk("bp_next_owner", 64'(obs_w), 64'd1);

    // Illegal op code.
    set_req(0, 3'b111, 64'd5, 64'd9);
    run_op(1);
    chk("ill_alu_cntrl", 64'(obs_alu_c), 64'd0);
    chk("ill_result", obs_res, 64'd0);
    chk("ill_flags", 64'(obs_fl), 64'b0100);
    chk("ill_err", 64'(obs_err), 64'd1);

    // Reset while the operation is executing.
    set_req(1, 3'b010, 64'd10, 64'd20);
    @(posedge clk);
    #1;
    req_valid = '0;
    chk("midrst_in_exec", 64'(busy), 64'd1);
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    m_cnt = 0;
    m_last = 1'b1;
    chk("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_op_count", 64'(op_count), 64'd0);
    $display("reset during EXEC");
    set_req(0, 3'b010, 64'd10, 64'd20);
    set_req(1, 3'b101, 64'hF0, 64'h0F);
    run_op(0);
    chk("fresh_owner", 64'(obs_w), 64'd0);
    chk("fresh_result", obs_res, 64'd30);
    run_op(0);

    // Random traffic; enough operations to wrap the narrow counter.
    for (int k = 0; k < 40; k++) begin
      req_valid = 2'($urandom_range(1, 3));
      for (int r = 0; r < 2; r++) begin
        req_cntrl[r] = 3'($urandom);
        req_A[r] = rand64();
        req_B[r] = rand64();
      end
      run_op($urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
